// File: rtl/fpu_adder_pkg.sv
// fpu_adder_pkg: shared constants and helpers for the FP adder datapath.
package fpu_adder_pkg;

   localparam int MW_DEFAULT = 27;
   localparam int EW_DEFAULT = 8;
   // Widest vector the leading-zero helper accepts.
   localparam int CLZ_MAXW   = 128;

   // Leading-zero count over the low n bits of vec; returns n when those bits are all zero.
   function automatic int clz(input logic [CLZ_MAXW-1:0] vec, input int n);
      int   cnt;
      logic found;
      cnt   = 0;
      found = 1'b0;
      for (int i = CLZ_MAXW - 1; i >= 0; i--) begin
         if (i < n && !found) begin
            if (vec[i]) found = 1'b1;
            else        cnt   = cnt + 1;
         end
      end
      return cnt;
   endfunction

endpackage

// File: rtl/lza_predict.sv
// lza_predict: leading-zero anticipator. Builds the indicator vector from the
// aligned operands and returns its leading-zero count (one less than or equal
// to the true count of the sum).
module lza_predict
   import fpu_adder_pkg::*;
#(
   parameter  int MW = MW_DEFAULT,
   localparam int SW = $clog2(MW + 1)
) (
   input  logic [MW-1:0] a,
   input  logic [MW-1:0] b,
   output logic [SW-1:0] p
);

   logic [MW-1:0] e;

   assign e[0] = a[0] ^ b[0];

   generate
      for (genvar gi = 1; gi < MW; gi++) begin : g_ind
         assign e[gi] = (a[gi] ^ b[gi]) ^ (a[gi-1] | b[gi-1]);
      end
   endgenerate

   // Prediction is the leading-zero count of the indicator (MW when it is all zero).
   always_comb begin
      p = SW'(clz(CLZ_MAXW'(e), MW));
   end

endmodule

// File: rtl/lza_norm_pipe.sv
// lza_norm_pipe: three-stage post-addition normaliser. Stage 1 predicts the
// shift with the LZA, stage 2 applies the exponent-limited coarse shift,
// stage 3 applies the one-bit correction and adjusts the exponent. All stages
// advance together under a single enable derived from the output handshake.
module lza_norm_pipe
   import fpu_adder_pkg::*;
#(
   parameter  int MW = MW_DEFAULT,
   parameter  int EW = EW_DEFAULT,
   parameter  int TW = 4,
   localparam int SW = $clog2(MW + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [MW-1:0] in_a,
   input  logic [MW-1:0] in_b,
   input  logic [MW-1:0] in_sum,
   input  logic [EW-1:0] in_exp,
   input  logic [TW-1:0] in_tag,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [MW-1:0] out_mant,
   output logic [EW-1:0] out_exp,
   output logic [SW-1:0] out_shift,
   output logic          out_corr,
   output logic          out_denorm,
   output logic          out_zero,
   output logic [TW-1:0] out_tag
);

   // Comparison width large enough for both shift counts and exponents.
   localparam int CW = ((EW > SW) ? EW : SW) + 1;

   typedef struct packed {
      logic [MW-1:0] sum;
      logic [EW-1:0] exp;
      logic [TW-1:0] tag;
      logic [SW-1:0] p;
      logic          z;
   } st1_t;

   typedef struct packed {
      logic [MW-1:0] sh;
      logic [SW-1:0] s1;
      logic [EW-1:0] lim;
      logic          lim1;
      logic          z;
      logic [EW-1:0] exp;
      logic [TW-1:0] tag;
   } st2_t;

   typedef struct packed {
      logic [MW-1:0] mant;
      logic [EW-1:0] exp;
      logic [SW-1:0] shift;
      logic          corr;
      logic          denorm;
      logic          zero;
      logic [TW-1:0] tag;
   } st3_t;

   st1_t          st1_reg, st1_next;
   st2_t          st2_reg, st2_next;
   st3_t          st3_reg, st3_next;
   logic          v1_reg, v2_reg, v3_reg;
   logic          en;
   logic [SW-1:0] p_lza;
   logic [EW-1:0] lim;
   logic          lim1;
   logic [SW-1:0] s1;
   logic          top;
   logic          corr;
   logic          denorm;
   logic [SW-1:0] shift;

   lza_predict #(.MW(MW)) u_lza (
      .a (in_a),
      .b (in_b),
      .p (p_lza)
   );

   assign en       = out_ready || !v3_reg;
   assign in_ready = en;

   // Stage 1: capture the item with its LZA prediction and zero flag.
   always_comb begin
      st1_next     = '0;
      st1_next.sum = in_sum;
      st1_next.exp = in_exp;
      st1_next.tag = in_tag;
      st1_next.p   = p_lza;
      st1_next.z   = (in_sum == '0);
   end

   // Stage 2: clamp the prediction so the exponent never drops below 1, then coarse-shift.
   always_comb begin
      lim           = (st1_reg.exp == '0) ? '0 : st1_reg.exp - EW'(1);
      lim1          = CW'(st1_reg.p) > CW'(lim);
      s1            = lim1 ? SW'(lim) : st1_reg.p;
      st2_next      = '0;
      st2_next.sh   = st1_reg.sum << s1;
      st2_next.s1   = s1;
      st2_next.lim  = lim;
      st2_next.lim1 = lim1;
      st2_next.z    = st1_reg.z;
      st2_next.exp  = st1_reg.exp;
      st2_next.tag  = st1_reg.tag;
   end

   // Stage 3: fix the LZA's possible one-bit underestimate and derive the final exponent.
   always_comb begin
      top    = st2_reg.sh[MW-1];
      corr   = !st2_reg.z && !st2_reg.lim1 && !top && (CW'(st2_reg.s1) < CW'(st2_reg.lim));
      shift  = st2_reg.s1 + SW'(corr);
      denorm = st2_reg.lim1 || (!top && !st2_reg.z && (CW'(st2_reg.s1) == CW'(st2_reg.lim)));
      st3_next        = '0;
      st3_next.tag    = st2_reg.tag;
      if (st2_reg.z) begin
         // A zero sum is reported as a clean zero regardless of the prediction.
         st3_next.zero = 1'b1;
      end else begin
         st3_next.mant   = corr ? (st2_reg.sh << 1) : st2_reg.sh;
         st3_next.shift  = shift;
         st3_next.corr   = corr;
         st3_next.denorm = denorm;
         st3_next.exp    = denorm ? '0 : st2_reg.exp - EW'(shift);
      end
   end

   // Pipeline registers: valids honour flush unconditionally, data moves only on enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_reg  <= 1'b0;
         v2_reg  <= 1'b0;
         v3_reg  <= 1'b0;
         st1_reg <= '0;
         st2_reg <= '0;
         st3_reg <= '0;
      end else begin
         if (flush) begin
            v1_reg <= 1'b0;
            v2_reg <= 1'b0;
            v3_reg <= 1'b0;
         end else if (en) begin
            v1_reg <= in_valid;
            v2_reg <= v1_reg;
            v3_reg <= v2_reg;
         end
         if (en) begin
            st1_reg <= st1_next;
            st2_reg <= st2_next;
            st3_reg <= st3_next;
         end
      end
   end

   assign out_valid  = v3_reg;
   assign out_mant   = st3_reg.mant;
   assign out_exp    = st3_reg.exp;
   assign out_shift  = st3_reg.shift;
   assign out_corr   = st3_reg.corr;
   assign out_denorm = st3_reg.denorm;
   assign out_zero   = st3_reg.zero;
   assign out_tag    = st3_reg.tag;

endmodule
